// File: rtl/mp_operand_pair_scheduler_if.sv
// Request and issue bus for mp_operand_pair_scheduler.
// The slave modport is the scheduler's view of the bus.
interface mp_operand_pair_scheduler_if #(
  parameter int TAG_W = 4
);
  logic             full_valid;
  logic             full_ready;
  logic [11:0]      full_x;
  logic [11:0]      full_y;
  logic             sa_valid;
  logic             sa_ready;
  logic [11:0]      sa_x;
  logic [4:0]       sa_s;
  logic             sb_valid;
  logic             sb_ready;
  logic [16:0]      sb_x;
  logic [4:0]       sb_s;
  logic             mul_valid;
  logic             mul_ready;
  logic [11:0]      mul_a;
  logic [11:0]      mul_b;
  logic [11:0]      mul_c;
  logic             mul_mode;
  logic [1:0]       mul_kind;
  logic [TAG_W-1:0] mul_tag;

  modport slave (
    input  full_valid, full_x, full_y,
    input  sa_valid, sa_x, sa_s,
    input  sb_valid, sb_x, sb_s,
    input  mul_ready,
    output full_ready, sa_ready, sb_ready,
    output mul_valid, mul_a, mul_b, mul_c,
    output mul_mode, mul_kind, mul_tag
  );

  modport master (
    output full_valid, full_x, full_y,
    output sa_valid, sa_x, sa_s,
    output sb_valid, sb_x, sb_s,
    output mul_ready,
    input  full_ready, sa_ready, sb_ready,
    input  mul_valid, mul_a, mul_b, mul_c,
    input  mul_mode, mul_kind, mul_tag
  );
endinterface

// File: rtl/mp_operand_pair_scheduler.sv
// Pairs A/B small jobs with a shared 5b multiplier into packed issues.
// MP_SCHED_STATS_EN adds pair/lone issue counters.
module mp_operand_pair_scheduler #(
  parameter int TIMEOUT = 8,
  parameter int TAG_W   = 4
) (
  input  logic clk,
  input  logic rst,
  mp_operand_pair_scheduler_if.slave bus
`ifdef MP_SCHED_STATS_EN
  ,
  output logic [15:0] stat_pairs,
  output logic [15:0] stat_lones
`endif
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  logic          a_v_q, a_v_d, b_v_q, b_v_d;
  logic [11:0]   a_x_q, a_x_d;
  logic [16:0]   b_x_q, b_x_d;
  logic [4:0]    a_s_q, a_s_d, b_s_q, b_s_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  logic             valid_q, valid_d, mode_q, mode_d;
  logic [11:0]      oa_q, oa_d, ob_q, ob_d, oc_q, oc_d;
  logic [1:0]       kind_q, kind_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic free, hs, full_rdy, full_fire;
  logic sel_pair, sel_mis, sel_toa, sel_tob;
  logic issue_a, issue_b;

  always_comb begin
    free     = !valid_q || bus.mul_ready;
    hs       = valid_q && bus.mul_ready;
    sel_pair = a_v_q && b_v_q && (a_s_q == b_s_q);
    sel_mis  = a_v_q && b_v_q && (a_s_q != b_s_q);
    sel_toa  = a_v_q && !b_v_q && (cnt_a_q == TO);
    sel_tob  = b_v_q && !a_v_q && (cnt_b_q == TO);
    full_rdy = free &&
      !(sel_pair || sel_mis || sel_toa || sel_tob);
    full_fire = full_rdy && bus.full_valid;
    issue_a  = free && (sel_pair || sel_mis || sel_toa);
    issue_b  = free && (sel_pair || sel_tob);
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    oa_d    = oa_q;
    ob_d    = ob_q;
    oc_d    = oc_q;
    kind_d  = kind_q;
    tag_d   = hs ? tag_q + TAG_W'(1) : tag_q;
    if (free) begin
      valid_d = 1'b0;
      unique case (1'b1)
        sel_pair: begin
          valid_d = 1'b1;
          mode_d  = 1'b1;
          kind_d  = 2'b01;
          oa_d    = a_x_q;
          ob_d    = b_x_q[11:0];
          oc_d    = {2'b0, a_s_q, b_x_q[16:12]};
        end
        sel_mis || sel_toa: begin
          valid_d = 1'b1;
          mode_d  = 1'b1;
          kind_d  = 2'b10;
          oa_d    = a_x_q;
          ob_d    = 12'h0;
          oc_d    = {2'b0, a_s_q, 5'b0};
        end
        sel_tob: begin
          valid_d = 1'b1;
          mode_d  = 1'b1;
          kind_d  = 2'b11;
          oa_d    = 12'h0;
          ob_d    = b_x_q[11:0];
          oc_d    = {2'b0, b_s_q, b_x_q[16:12]};
        end
        full_fire: begin
          valid_d = 1'b1;
          mode_d  = 1'b0;
          kind_d  = 2'b00;
          oa_d    = bus.full_x;
          ob_d    = 12'h0;
          oc_d    = bus.full_y;
        end
        default: ;
      endcase
    end
  end

  // A slot never refills in the cycle it drains: ready is !valid.
  always_comb begin
    a_v_d   = a_v_q;
    a_x_d   = a_x_q;
    a_s_d   = a_s_q;
    cnt_a_d = cnt_a_q;
    if (issue_a) begin
      a_v_d = 1'b0;
    end else if (bus.sa_valid && !a_v_q) begin
      a_v_d   = 1'b1;
      a_x_d   = bus.sa_x;
      a_s_d   = bus.sa_s;
      cnt_a_d = '0;
    end else if (a_v_q && cnt_a_q != TO) begin
      cnt_a_d = cnt_a_q + CW'(1);
    end
  end

  always_comb begin
    b_v_d   = b_v_q;
    b_x_d   = b_x_q;
    b_s_d   = b_s_q;
    cnt_b_d = cnt_b_q;
    if (issue_b) begin
      b_v_d = 1'b0;
    end else if (bus.sb_valid && !b_v_q) begin
      b_v_d   = 1'b1;
      b_x_d   = bus.sb_x;
      b_s_d   = bus.sb_s;
      cnt_b_d = '0;
    end else if (b_v_q && cnt_b_q != TO) begin
      cnt_b_d = cnt_b_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v_q   <= 1'b0;
      a_x_q   <= '0;
      a_s_q   <= '0;
      cnt_a_q <= '0;
      b_v_q   <= 1'b0;
      b_x_q   <= '0;
      b_s_q   <= '0;
      cnt_b_q <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      oa_q    <= '0;
      ob_q    <= '0;
      oc_q    <= '0;
      kind_q  <= '0;
      tag_q   <= '0;
    end else begin
      a_v_q   <= a_v_d;
      a_x_q   <= a_x_d;
      a_s_q   <= a_s_d;
      cnt_a_q <= cnt_a_d;
      b_v_q   <= b_v_d;
      b_x_q   <= b_x_d;
      b_s_q   <= b_s_d;
      cnt_b_q <= cnt_b_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      oa_q    <= oa_d;
      ob_q    <= ob_d;
      oc_q    <= oc_d;
      kind_q  <= kind_d;
      tag_q   <= tag_d;
    end
  end

`ifdef MP_SCHED_STATS_EN
  logic [15:0] pairs_q, pairs_d, lones_q, lones_d;

  always_comb begin
    pairs_d = pairs_q;
    lones_d = lones_q;
    if (hs && kind_q == 2'b01) pairs_d = pairs_q + 16'd1;
    if (hs && kind_q[1])       lones_d = lones_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pairs_q <= '0;
      lones_q <= '0;
    end else begin
      pairs_q <= pairs_d;
      lones_q <= lones_d;
    end
  end

  assign stat_pairs = pairs_q;
  assign stat_lones = lones_q;
`endif

  assign bus.full_ready = full_rdy;
  assign bus.sa_ready   = !a_v_q;
  assign bus.sb_ready   = !b_v_q;
  assign bus.mul_valid  = valid_q;
  assign bus.mul_mode   = mode_q;
  assign bus.mul_a      = oa_q;
  assign bus.mul_b      = ob_q;
  assign bus.mul_c      = oc_q;
  assign bus.mul_kind   = kind_q;
  assign bus.mul_tag    = tag_q;
endmodule

// File: tb/tb_mp_operand_pair_scheduler.sv
// Scoreboard bench for mp_operand_pair_scheduler.
// Directed vectors push expected issues; a monitor pops on handshake.
module tb_mp_operand_pair_scheduler;
  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
    logic        mode;
    logic [1:0]  kind;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [3:0] tag_exp = 4'd0;

  mp_operand_pair_scheduler_if #(.TAG_W(4)) bus();

`ifdef MP_SCHED_STATS_EN
  logic [15:0] stat_pairs, stat_lones;
`endif

  mp_operand_pair_scheduler #(.TIMEOUT(8), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MP_SCHED_STATS_EN
    ,
    .stat_pairs (stat_pairs),
    .stat_lones (stat_lones)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [11:0] a, input logic [11:0] b,
                      input logic [11:0] c, input logic m,
                      input logic [1:0] k);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.mode = m; e.kind = k;
    e.tag = tag_exp;
    tag_exp = tag_exp + 4'd1;
    q.push_back(e);
  endtask

  task automatic drain(input string name, input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d issues outstanding, want 0", name, q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.mul_valid && bus.mul_ready) begin
      exp_t e, g;
      g.a = bus.mul_a; g.b = bus.mul_b; g.c = bus.mul_c;
      g.mode = bus.mul_mode; g.kind = bus.mul_kind;
      g.tag = bus.mul_tag;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %h want none", g);
      end else begin
        e = q.pop_front();
        if (g != e) begin
          errors++;
          $display("FAIL issue: got a=%h b=%h c=%h m=%0d k=%0d t=%0d want a=%h b=%h c=%h m=%0d k=%0d t=%0d",
                   g.a, g.b, g.c, g.mode, g.kind, g.tag,
                   e.a, e.b, e.c, e.mode, e.kind, e.tag);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.full_valid = 0; bus.full_x = '0; bus.full_y = '0;
    bus.sa_valid = 0; bus.sa_x = '0; bus.sa_s = '0;
    bus.sb_valid = 0; bus.sb_x = '0; bus.sb_s = '0;
  endtask

  initial begin
    idle_inputs();
    bus.mul_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", int'(bus.mul_valid), 0);
    chk("rst_a", int'(bus.mul_a), 0);
    chk("rst_b", int'(bus.mul_b), 0);
    chk("rst_c", int'(bus.mul_c), 0);
    chk("rst_mode", int'(bus.mul_mode), 0);
    chk("rst_kind", int'(bus.mul_kind), 0);
    chk("rst_tag", int'(bus.mul_tag), 0);
    chk("rst_sa_ready", int'(bus.sa_ready), 1);
    rst = 1'b0;
    tick();

    // full job
    bus.full_valid = 1; bus.full_x = 12'h0FF; bus.full_y = 12'h003;
    #1;
    chk("full_ready_idle", int'(bus.full_ready), 1);
    push(12'h0FF, 12'h000, 12'h003, 1'b0, 2'b00);
    tick();
    bus.full_valid = 0;
    chk("full_latency", int'(bus.mul_valid), 1);
    drain("full", 5);

    // pair accepted together
    bus.sa_valid = 1; bus.sa_x = 12'hABC; bus.sa_s = 5'h13;
    bus.sb_valid = 1; bus.sb_x = 17'h12345; bus.sb_s = 5'h13;
    push(12'hABC, 12'h345, 12'h272, 1'b1, 2'b01);
    tick();
    idle_inputs();
    chk("pair_sa_busy", int'(bus.sa_ready), 0);
    tick();
    chk("pair_valid", int'(bus.mul_valid), 1);
    drain("pair", 5);
    repeat (3) tick();

    // pair beats a waiting full job
    bus.sa_valid = 1; bus.sa_x = 12'h111; bus.sa_s = 5'h05;
    bus.sb_valid = 1; bus.sb_x = 17'h00222; bus.sb_s = 5'h05;
    tick();
    idle_inputs();
    bus.full_valid = 1; bus.full_x = 12'h456; bus.full_y = 12'h789;
    #1;
    chk("full_blocked", int'(bus.full_ready), 0);
    push(12'h111, 12'h222, 12'h0A0, 1'b1, 2'b01);
    push(12'h456, 12'h000, 12'h789, 1'b0, 2'b00);
    tick();
    chk("full_ready_after_pair", int'(bus.full_ready), 1);
    tick();
    bus.full_valid = 0;
    drain("pair_then_full", 5);
    repeat (2) tick();

    // lone A timeout
    bus.sa_valid = 1; bus.sa_x = 12'h00F; bus.sa_s = 5'h01;
    push(12'h00F, 12'h000, 12'h020, 1'b1, 2'b10);
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wait_sa_ready_%0d", i), int'(bus.sa_ready), 0);
      tick();
    end
    chk("timeout_not_early", int'(bus.mul_valid), 0);
    tick();
    chk("timeout_issue", int'(bus.mul_valid), 1);
    drain("timeout", 5);
    repeat (2) tick();

    // mismatch with a stalled multiplier
    bus.mul_ready = 0;
    bus.sa_valid = 1; bus.sa_x = 12'h321; bus.sa_s = 5'h01;
    bus.sb_valid = 1; bus.sb_x = 17'h1ABCD; bus.sb_s = 5'h02;
    push(12'h321, 12'h000, 12'h020, 1'b1, 2'b10);
    push(12'h000, 12'hBCD, 12'h05A, 1'b1, 2'b11);
    tick();
    idle_inputs();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid_%0d", i), int'(bus.mul_valid), 1);
      chk($sformatf("stall_a_%0d", i), int'(bus.mul_a), 12'h321);
      chk($sformatf("stall_c_%0d", i), int'(bus.mul_c), 12'h020);
      chk($sformatf("stall_kind_%0d", i), int'(bus.mul_kind), 2);
      chk($sformatf("stall_tag_%0d", i), int'(bus.mul_tag), 5);
      chk($sformatf("stall_full_rdy_%0d", i), int'(bus.full_ready), 0);
      tick();
    end
    bus.mul_ready = 1;
    drain("mismatch", 20);
    repeat (2) tick();

    // reset with work pending
    bus.mul_ready = 0;
    bus.full_valid = 1; bus.full_x = 12'h777; bus.full_y = 12'h001;
    tick();
    idle_inputs();
    bus.sa_valid = 1; bus.sa_x = 12'h555; bus.sa_s = 5'h07;
    bus.sb_valid = 1; bus.sb_x = 17'h00666; bus.sb_s = 5'h07;
    tick();
    idle_inputs();
    chk("pre_rst_sa_busy", int'(bus.sa_ready), 0);
    chk("pre_rst_valid", int'(bus.mul_valid), 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.mul_valid), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.mul_ready = 1;
    tag_exp = 4'd0;
    tick();
    chk("post_rst_valid", int'(bus.mul_valid), 0);
    chk("post_rst_tag", int'(bus.mul_tag), 0);
    chk("post_rst_sa_ready", int'(bus.sa_ready), 1);
    chk("post_rst_sb_ready", int'(bus.sb_ready), 1);
    bus.sa_valid = 1; bus.sa_x = 12'hFFF; bus.sa_s = 5'h1F;
    bus.sb_valid = 1; bus.sb_x = 17'h1FFFF; bus.sb_s = 5'h1F;
    push(12'hFFF, 12'hFFF, 12'h3FF, 1'b1, 2'b01);
    tick();
    idle_inputs();
    drain("post_rst_pair", 5);
    repeat (3) tick();
    chk("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
